comm_tx_queue: RTL
==================

Name: comm_tx_queue

Overview:
- Memory-mapped serial transmitter for the J1 I/O bus, one peripheral slot alongside the communications link.
- J1 writes bytes into an internal FIFO. An 8N1 serializer drains the FIFO onto `tx` at a fixed baud rate.
- Status (busy, full, empty, overflow, fill count) is readable so firmware can poll instead of blocking.
- Selected by the SoC address decoder through `cs`. `d_out` feeds the J1 read mux.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz.
- BAUD, 115200, line rate. Bit period BIT_CYC = CLK_FREQ/BAUD, integer-truncated (434 at defaults); must be >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `d_in`  in  16  J1 write data.
- `cs`  in  1  chip select from the address decoder.
- `addr`  in  4  register offset (J1 address bits 3:0).
- `rd`  in  1  J1 read strobe.
- `wr`  in  1  J1 write strobe, one cycle per access.
- `d_out`  out  16  read data, combinational.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Single clock `clk`; reset is asynchronous and active-high on `rst`.

Register map (addr), all accesses qualified by `cs`:
- 0x0 DATA, write: push `d_in[7:0]`; bits 15:8 ignored.
- 0x2 STATUS, read: bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits 15:4 count (zero-extended, 0..FIFO_DEPTH).
- 0x4 CTRL, write: bit0=1 clears FIFO, bit1=1 clears overflow.
- Other offsets: writes ignored; reads return 0.

Read path:
- `d_out` = STATUS when `cs & rd & addr==0x2`, otherwise 0.
- Reads have no side effects.

Reset state:
- `tx`=1, `busy`=0, FIFO empty, count 0, overflow 0, FSM IDLE, baud counter 0, `d_out`=0.

FIFO:
- Push happens on `cs & wr & addr==0x0`.
- Push while full (full evaluated at the start of the cycle) is dropped and sets sticky overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count is unchanged and both succeed.
- Pointers wrap modulo FIFO_DEPTH.
- CTRL clear and a push in the same cycle: clear wins and the push is discarded; overflow is not set.

Serializer FSM (IDLE, START, DATA, STOP):
- IDLE: if FIFO not empty, pop into an 8-bit shift register, reset the baud counter, go to START on the next edge. Pop-to-start-bit latency is 1 cycle.
- START: `tx`=0 for BIT_CYC cycles, then DATA.
- DATA: `tx`=shift[0], LSB first. Shift after each BIT_CYC. After 8 bits, go to STOP.
- STOP: `tx`=1 for BIT_CYC cycles. Then, if FIFO not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*BIT_CYC cycles.
- Baud counter counts 0..BIT_CYC-1; terminal count advances the bit.

Boundary conditions:
- FIFO clear mid-frame: the current frame completes unaltered; queued bytes are discarded.
- `busy` = (state != IDLE) | !empty, registered-free (combinational from state and count).
- `rst` asserted mid-frame: `tx` goes high immediately and all state returns to reset values.

Decomposition:
- Shared package `comm_pkg`: register offsets (REG_DATA=0x0, REG_STATUS=0x2, REG_CTRL=0x4), status bit indices, CTRL bit indices, FSM state encoding.
- Sub-module `comm_sync_fifo` (parameterized width/depth):
  - Inputs: push, pop, clear.
  - Outputs: dout, full, empty, count.
  - Same clock/reset convention.
- Top holds the register decode, overflow flag, baud counter and FSM.

Test Plan (CLK_FREQ=40, BAUD=10, so BIT_CYC=4; FIFO_DEPTH=4):
- Reset release, no access → `tx`=1, `busy`=0, STATUS read = 0x0004 (empty, count 0).
- Write DATA 0x0055 → start bit begins 1 cycle after the push edge. `tx` sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1. Total 40 cycles, then `busy`=0.
- Write 0xA1, 0xB2, 0xC3 back-to-back → three frames contiguous, no idle cycles between stop and next start. STATUS count reads 2 right after the third write.
- Write 6 bytes in consecutive cycles (first pops immediately; 4 fill the FIFO) → 6th dropped. STATUS = full|overflow|busy, count 4. Only 5 frames transmitted. CTRL 0x2 then clears overflow.
- Queue 3 bytes, write CTRL 0x1 during the DATA state of frame 1 → frame 1 completes; count 0; no further frames. CTRL clear coinciding with a DATA push leaves the FIFO empty.
- Assert `rst` for 1 cycle during the DATA state → `tx`=1 asynchronously, STATUS = 0x0004 afterwards. A new write transmits a clean full frame.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared definitions for the J1 serial transmitter slot: register offsets,
// status/control bit positions and the serializer state encoding.
package comm_pkg;

   // Register offsets (J1 address bits 3:0)
   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h2;
   localparam logic [3:0] REG_CTRL   = 4'h4;

   // STATUS word bit positions; the fill count occupies bits 15:4
   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_COUNT_LSB = 4;

   // CTRL write bit positions
   localparam int CTRL_CLR_FIFO = 0;
   localparam int CTRL_CLR_OVF  = 1;

   // Serializer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Bit period in clock cycles, integer-truncated
   function automatic int bit_cycles(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/comm_sync_fifo.sv
// Synchronous FIFO with occupancy count. Read data is presented
// combinationally from the head entry so the consumer can take it in the same
// cycle it pops. A clear empties the FIFO and overrides any push or pop in
// the same cycle.
module comm_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic push_ok;
   logic pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];

   // Full/empty are sampled at the start of the cycle, so a push while full is
   // refused even if a pop frees an entry in the same cycle.
   assign push_ok = push & ~full & ~clear;
   assign pop_ok  = pop & ~empty & ~clear;

   // Next pointer and occupancy values; pointers wrap naturally (power-of-two depth)
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (clear) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
         endcase
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage array; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/comm_tx_queue.sv
// Memory-mapped 8N1 transmitter for the J1 I/O bus. Firmware pushes bytes
// into a FIFO through DATA, polls STATUS, and uses CTRL to flush the FIFO or
// clear the sticky overflow flag. The serializer drains the FIFO back to back
// with no idle gap between frames.
module comm_tx_queue
   import comm_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out,
   output logic        tx,
   output logic        busy
);

   localparam int BIT_CYC = bit_cycles(CLK_FREQ, BAUD);
   localparam int CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
   localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

   // Bus decode
   logic push_req;
   logic ctrl_wr;
   logic clr_fifo;
   logic clr_ovf;
   logic status_rd;

   // FIFO interface
   logic [7:0]     fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FCW-1:0] fifo_count;
   logic           load_frame;

   // Serializer state
   tx_state_t         state_reg, state_next;
   logic [CNT_W-1:0]  baud_cnt_reg, baud_cnt_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic              baud_tick;

   logic        overflow_reg;
   logic [15:0] status_word;

   // Upper data bits carry nothing for this peripheral
   logic unused_d_in;
   assign unused_d_in = &{1'b0, d_in[15:8]};

   assign push_req  = cs & wr & (addr == REG_DATA);
   assign ctrl_wr   = cs & wr & (addr == REG_CTRL);
   assign clr_fifo  = ctrl_wr & d_in[CTRL_CLR_FIFO];
   assign clr_ovf   = ctrl_wr & d_in[CTRL_CLR_OVF];
   assign status_rd = cs & rd & (addr == REG_STATUS);

   assign baud_tick = (baud_cnt_reg == CNT_W'(BIT_CYC - 1));

   // A new byte is taken either from idle or at the last cycle of a stop bit,
   // which is what makes consecutive frames contiguous. A flush in the same
   // cycle suppresses the load so no discarded byte ever reaches the line.
   assign load_frame = ~fifo_empty & ~clr_fifo &
                       ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & baud_tick));

   comm_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (load_frame),
      .clear (clr_fifo),
      .din   (d_in[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow: set by a refused push, cleared only by CTRL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_reg <= 1'b0;
      end else if (clr_ovf) begin
         overflow_reg <= 1'b0;
      end else if (push_req & fifo_full & ~clr_fifo) begin
         overflow_reg <= 1'b1;
      end
   end

   // Serializer state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Serializer next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (load_frame) state_next = ST_START;
         ST_START: if (baud_tick) state_next = ST_DATA;
         ST_DATA:  if (baud_tick && (bit_idx_reg == 3'd7)) state_next = ST_STOP;
         ST_STOP:  if (baud_tick) state_next = load_frame ? ST_START : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Baud counter, bit index and shift register updates
   always_comb begin
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      if (load_frame) begin
         baud_cnt_next = '0;
         bit_idx_next  = '0;
         shift_next    = fifo_dout;
      end else if (state_reg == ST_IDLE) begin
         baud_cnt_next = '0;
      end else if (baud_tick) begin
         baud_cnt_next = '0;
         if (state_reg == ST_DATA) begin
            bit_idx_next = bit_idx_reg + 1'b1;
            shift_next   = {1'b0, shift_reg[7:1]};
         end
      end else begin
         baud_cnt_next = baud_cnt_reg + 1'b1;
      end
   end

   // Serializer datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
      end
   end

   // Line and busy outputs decoded from state; reset forces the line idle at once
   always_comb begin
      tx   = 1'b1;
      busy = (state_reg != ST_IDLE) | ~fifo_empty;
      case (state_reg)
         ST_START: tx = 1'b0;
         ST_DATA:  tx = shift_reg[0];
         default:  tx = 1'b1;
      endcase
   end

   // STATUS assembly and read mux; any other read returns zero
   always_comb begin
      status_word                      = '0;
      status_word[STAT_BUSY]           = busy;
      status_word[STAT_FULL]           = fifo_full;
      status_word[STAT_EMPTY]          = fifo_empty;
      status_word[STAT_OVF]            = overflow_reg;
      status_word[15:STAT_COUNT_LSB]   = 12'(fifo_count);
      d_out                            = status_rd ? status_word : 16'h0000;
   end

endmodule
